// File: rtl/rename_stage.sv
// Register rename stage: two-slot RAT lookup/update with intra-group bypass
// and a single branch checkpoint for mispredict rollback.
module rename_stage #(
    parameter  int NUM_AREGS = 16,
    parameter  int NUM_PREGS = 64,
    localparam int P = $clog2(NUM_PREGS),
    localparam int A = $clog2(NUM_AREGS)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         prev_valid,
    input  logic         enabled,
    input  logic         next_enabled,
    input  logic         next_stalled,
    output logic         stalled,
    output logic         valid,
    input  logic [A-1:0] rs1_1,
    input  logic [A-1:0] rs2_1,
    input  logic [A-1:0] rd_1,
    input  logic [A-1:0] rs1_2,
    input  logic [A-1:0] rs2_2,
    input  logic [A-1:0] rd_2,
    input  logic         writes_1,
    input  logic         is_branch_1,
    input  logic         is_noop_1,
    input  logic         writes_2,
    input  logic         is_branch_2,
    input  logic         is_noop_2,
    input  logic [P-1:0] preg1,
    input  logic [P-1:0] preg2,
    input  logic [1:0]   num_execute,
    output logic [P-1:0] prs1_1,
    output logic [P-1:0] prs2_1,
    output logic [P-1:0] prd_1,
    output logic [P-1:0] old_prd_1,
    output logic [P-1:0] prs1_2,
    output logic [P-1:0] prs2_2,
    output logic [P-1:0] prd_2,
    output logic [P-1:0] old_prd_2,
    output logic         out_noop_1,
    output logic         out_noop_2,
    input  logic         restore,
    input  logic         resolve,
    output logic         ckpt_valid
);

    logic [P-1:0] rat_q  [NUM_AREGS];
    logic [P-1:0] ckpt_q [NUM_AREGS];
    logic [P-1:0] rat1_d [NUM_AREGS];
    logic [P-1:0] rat2_d [NUM_AREGS];
    logic         ckpt_valid_q, valid_q;
    logic [P-1:0] prs1_1_q, prs2_1_q, prd_1_q, old_prd_1_q;
    logic [P-1:0] prs1_2_q, prs2_2_q, prd_2_q, old_prd_2_q;
    logic         out_noop_1_q, out_noop_2_q;

    logic         ren1, ren2, br1, br2, branch_block, accept, restore_en;
    logic [P-1:0] new1, new2;
    logic [P-1:0] prs1_1_d, prs2_1_d, prd_1_d, old_prd_1_d;
    logic [P-1:0] prs1_2_d, prs2_2_d, prd_2_d, old_prd_2_d;

    // num_execute is guaranteed upstream to match the renaming slot count.
    logic         unused_num_execute;
    assign unused_num_execute = ^num_execute;

    assign ren1         = !is_noop_1 && writes_1 && (rd_1 != '0);
    assign ren2         = !is_noop_2 && writes_2 && (rd_2 != '0);
    assign br1          = is_branch_1;
    assign br2          = is_branch_2 && !is_branch_1;
    assign branch_block = prev_valid && (is_branch_1 || is_branch_2) && ckpt_valid_q;
    assign restore_en   = restore && ckpt_valid_q;
    assign accept       = enabled && prev_valid && !restore && !clear && !branch_block;
    assign new1         = preg1;
    assign new2         = ren1 ? preg2 : preg1;

    // Rename lookup with slot-1 -> slot-2 bypass on sources and displaced mapping.
    always_comb begin
        prs1_1_d    = rat_q[rs1_1];
        prs2_1_d    = rat_q[rs2_1];
        prd_1_d     = ren1 ? new1 : '0;
        old_prd_1_d = ren1 ? rat_q[rd_1] : '0;
        prs1_2_d    = (ren1 && rs1_2 == rd_1) ? new1 : rat_q[rs1_2];
        prs2_2_d    = (ren1 && rs2_2 == rd_1) ? new1 : rat_q[rs2_2];
        prd_2_d     = ren2 ? new2 : '0;
        old_prd_2_d = '0;
        if (ren2) old_prd_2_d = (ren1 && rd_2 == rd_1) ? new1 : rat_q[rd_2];
    end

    // Post-slot-1 and post-slot-2 RAT images; slot 2 wins on a shared rd.
    always_comb begin
        rat1_d = rat_q;
        if (ren1) rat1_d[rd_1] = new1;
        rat2_d = rat1_d;
        if (ren2) rat2_d[rd_2] = new2;
    end

    // RAT, checkpoint and pipeline output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_AREGS; i++) begin
                rat_q[i]  <= P'(i);
                ckpt_q[i] <= P'(i);
            end
            ckpt_valid_q <= 1'b0;
            valid_q      <= 1'b0;
            prs1_1_q     <= '0;
            prs2_1_q     <= '0;
            prd_1_q      <= '0;
            old_prd_1_q  <= '0;
            prs1_2_q     <= '0;
            prs2_2_q     <= '0;
            prd_2_q      <= '0;
            old_prd_2_q  <= '0;
            out_noop_1_q <= 1'b0;
            out_noop_2_q <= 1'b0;
        end else begin
            if (restore_en)  rat_q <= ckpt_q;
            else if (accept) rat_q <= rat2_d;

            if (accept && br1)      ckpt_q <= rat1_d;
            else if (accept && br2) ckpt_q <= rat2_d;

            if (restore_en)                   ckpt_valid_q <= 1'b0;
            else if (accept && (br1 || br2)) ckpt_valid_q <= 1'b1;
            else if (resolve)                 ckpt_valid_q <= 1'b0;

            if (restore_en || clear) valid_q <= 1'b0;
            else if (enabled)        valid_q <= accept;
            else if (next_enabled)   valid_q <= 1'b0;

            if (accept) begin
                prs1_1_q     <= prs1_1_d;
                prs2_1_q     <= prs2_1_d;
                prd_1_q      <= prd_1_d;
                old_prd_1_q  <= old_prd_1_d;
                prs1_2_q     <= prs1_2_d;
                prs2_2_q     <= prs2_2_d;
                prd_2_q      <= prd_2_d;
                old_prd_2_q  <= old_prd_2_d;
                out_noop_1_q <= is_noop_1;
                out_noop_2_q <= is_noop_2;
            end
        end
    end

    assign stalled    = (valid_q && next_stalled) || branch_block;
    assign valid      = valid_q;
    assign ckpt_valid = ckpt_valid_q;
    assign prs1_1     = prs1_1_q;
    assign prs2_1     = prs2_1_q;
    assign prd_1      = prd_1_q;
    assign old_prd_1  = old_prd_1_q;
    assign prs1_2     = prs1_2_q;
    assign prs2_2     = prs2_2_q;
    assign prd_2      = prd_2_q;
    assign old_prd_2  = old_prd_2_q;
    assign out_noop_1 = out_noop_1_q;
    assign out_noop_2 = out_noop_2_q;

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage with hand-computed expectations.
module tb_rename_stage;

    localparam int A = 4;
    localparam int P = 6;

    logic         clk = 1'b0;
    logic         reset, clear, prev_valid, enabled, next_enabled, next_stalled;
    logic         stalled, valid;
    logic [A-1:0] rs1_1, rs2_1, rd_1, rs1_2, rs2_2, rd_2;
    logic         writes_1, is_branch_1, is_noop_1, writes_2, is_branch_2, is_noop_2;
    logic [P-1:0] preg1, preg2;
    logic [1:0]   num_execute;
    logic [P-1:0] prs1_1, prs2_1, prd_1, old_prd_1, prs1_2, prs2_2, prd_2, old_prd_2;
    logic         out_noop_1, out_noop_2, restore, resolve, ckpt_valid;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    rename_stage #(.NUM_AREGS(16), .NUM_PREGS(64)) dut (
        .clk(clk), .reset(reset), .clear(clear), .prev_valid(prev_valid),
        .enabled(enabled), .next_enabled(next_enabled), .next_stalled(next_stalled),
        .stalled(stalled), .valid(valid),
        .rs1_1(rs1_1), .rs2_1(rs2_1), .rd_1(rd_1),
        .rs1_2(rs1_2), .rs2_2(rs2_2), .rd_2(rd_2),
        .writes_1(writes_1), .is_branch_1(is_branch_1), .is_noop_1(is_noop_1),
        .writes_2(writes_2), .is_branch_2(is_branch_2), .is_noop_2(is_noop_2),
        .preg1(preg1), .preg2(preg2), .num_execute(num_execute),
        .prs1_1(prs1_1), .prs2_1(prs2_1), .prd_1(prd_1), .old_prd_1(old_prd_1),
        .prs1_2(prs1_2), .prs2_2(prs2_2), .prd_2(prd_2), .old_prd_2(old_prd_2),
        .out_noop_1(out_noop_1), .out_noop_2(out_noop_2),
        .restore(restore), .resolve(resolve), .ckpt_valid(ckpt_valid)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        prev_valid = 0; enabled = 0; next_enabled = 0; next_stalled = 0;
        clear = 0; restore = 0; resolve = 0;
        is_noop_1 = 1; writes_1 = 0; is_branch_1 = 0; rd_1 = 0; rs1_1 = 0; rs2_1 = 0;
        is_noop_2 = 1; writes_2 = 0; is_branch_2 = 0; rd_2 = 0; rs1_2 = 0; rs2_2 = 0;
        preg1 = 0; preg2 = 0; num_execute = 0;
    endtask

    task automatic slot1(input logic w, input logic br, input logic [A-1:0] rd,
                         input logic [A-1:0] s1, input logic [A-1:0] s2);
        is_noop_1 = 0; writes_1 = w; is_branch_1 = br; rd_1 = rd; rs1_1 = s1; rs2_1 = s2;
    endtask

    task automatic slot2(input logic w, input logic br, input logic [A-1:0] rd,
                         input logic [A-1:0] s1, input logic [A-1:0] s2);
        is_noop_2 = 0; writes_2 = w; is_branch_2 = br; rd_2 = rd; rs1_2 = s1; rs2_2 = s2;
    endtask

    task automatic send(input logic [P-1:0] p1, input logic [P-1:0] p2, input logic [1:0] n);
        preg1 = p1; preg2 = p2; num_execute = n;
        prev_valid = 1; enabled = 1;
        step();
        idle();
    endtask

    // Read two RAT entries through a noop group (noop groups never write the RAT).
    task automatic probe(input string tag, input logic [A-1:0] a, input logic [A-1:0] b,
                         input logic [P-1:0] ea, input logic [P-1:0] eb);
        idle();
        rs1_1 = a; rs2_1 = b;
        send(0, 0, 0);
        check({tag, "_a"}, prs1_1, ea);
        check({tag, "_b"}, prs2_1, eb);
    endtask

    initial begin
        idle();
        reset = 0;
        step(); step();
        check("rst_valid", valid, 0);
        check("rst_ckpt", ckpt_valid, 0);
        check("rst_prd1", prd_1, 0);
        check("rst_old2", old_prd_2, 0);
        check("rst_noop1", out_noop_1, 0);
        reset = 1;
        probe("rst_rat", 7, 15, 7, 15);

        // Dependent pair with intra-group bypass.
        slot1(1, 0, 3, 3, 0); slot2(1, 0, 4, 3, 0);
        send(20, 21, 2);
        check("g1_valid", valid, 1);
        check("g1_prs1_1", prs1_1, 3);
        check("g1_prd_1", prd_1, 20);
        check("g1_old_1", old_prd_1, 3);
        check("g1_prs1_2", prs1_2, 20);
        check("g1_prd_2", prd_2, 21);
        check("g1_old_2", old_prd_2, 4);
        check("hold_prd_2", prd_2, 21);

        // Same destination in both slots.
        slot1(1, 0, 5, 0, 0); slot2(1, 0, 5, 5, 0);
        send(30, 31, 2);
        check("g2_old_1", old_prd_1, 5);
        check("g2_old_2", old_prd_2, 30);
        check("g2_prs1_2", prs1_2, 30);
        probe("g2_rat", 5, 3, 31, 20);

        // Writes to r0 never rename.
        slot1(1, 0, 0, 0, 0);
        send(33, 34, 0);
        check("r0_prd_1", prd_1, 0);
        check("r0_old_1", old_prd_1, 0);
        check("r0_noop_2", out_noop_2, 1);
        probe("r0_rat", 0, 4, 0, 21);

        // Enabled with no incoming group drops valid.
        enabled = 1;
        step();
        idle();
        check("empty_valid", valid, 0);

        // Restore without a checkpoint leaves the RAT alone.
        restore = 1;
        step();
        idle();
        probe("norestore", 5, 3, 31, 20);

        // Branch in slot 1, then mispredict.
        slot1(1, 1, 2, 0, 0); slot2(1, 0, 2, 0, 0);
        send(40, 41, 2);
        check("br1_ckpt", ckpt_valid, 1);
        check("br1_old_2", old_prd_2, 40);
        probe("br1_rat", 2, 3, 41, 20);
        restore = 1;
        step();
        idle();
        check("rst1_ckpt", ckpt_valid, 0);
        check("rst1_valid", valid, 0);
        probe("rst1_rat", 2, 5, 40, 31);

        // Branch in slot 2 only sets the checkpoint.
        slot1(1, 0, 6, 0, 0); slot2(1, 1, 7, 0, 0);
        send(50, 51, 2);
        check("br2_ckpt", ckpt_valid, 1);

        // Second branch group blocks until resolve.
        slot1(1, 1, 6, 6, 0); slot2(1, 0, 6, 6, 0);
        preg1 = 52; preg2 = 53; num_execute = 2;
        prev_valid = 1; enabled = 1;
        #1;
        check("blk_stalled", stalled, 1);
        step();
        check("blk_stalled2", stalled, 1);
        check("blk_ckpt", ckpt_valid, 1);
        resolve = 1;
        step();
        check("res_ckpt", ckpt_valid, 0);
        check("res_stalled", stalled, 0);
        resolve = 0;
        step();
        idle();
        check("acc_valid", valid, 1);
        check("acc_ckpt", ckpt_valid, 1);
        check("acc_prs1_1", prs1_1, 50);
        check("acc_old_1", old_prd_1, 50);
        check("acc_prs1_2", prs1_2, 52);
        check("acc_old_2", old_prd_2, 52);
        check("acc_prd_2", prd_2, 53);

        // Restore and resolve together: restore wins.
        restore = 1; resolve = 1;
        step();
        idle();
        check("rr_ckpt", ckpt_valid, 0);
        check("rr_valid", valid, 0);
        probe("rr_rat", 6, 7, 52, 51);

        // Resolve alongside a new branch accept keeps the checkpoint.
        slot1(0, 1, 0, 0, 0);
        resolve = 1;
        send(0, 0, 0);
        check("resbr_ckpt", ckpt_valid, 1);
        resolve = 1;
        step();
        idle();
        check("resonly_ckpt", ckpt_valid, 0);

        // Downstream stall holds outputs.
        probe("stall_pre", 6, 0, 52, 0);
        next_stalled = 1;
        #1;
        check("ds_stalled", stalled, 1);
        step();
        check("ds_valid", valid, 1);
        check("ds_prs1_1", prs1_1, 52);
        next_stalled = 0;
        next_enabled = 1;
        step();
        idle();
        check("ne_valid", valid, 0);

        // Clear drops the group and leaves the RAT untouched.
        slot1(1, 0, 8, 0, 0);
        clear = 1;
        send(60, 0, 1);
        check("clr_valid", valid, 0);
        probe("clr_rat", 8, 2, 8, 40);

        // Reset mid-stream with a checkpoint held.
        slot1(1, 1, 9, 0, 0);
        send(61, 0, 1);
        check("mid_ckpt_set", ckpt_valid, 1);
        slot1(1, 0, 10, 0, 0);
        preg1 = 62; prev_valid = 1; enabled = 1; restore = 1; resolve = 1; clear = 1;
        reset = 0;
        step();
        idle();
        check("mid_valid", valid, 0);
        check("mid_ckpt", ckpt_valid, 0);
        check("mid_prd_1", prd_1, 0);
        reset = 1;
        probe("mid_rat", 6, 9, 6, 9);
        probe("mid_rat2", 10, 2, 10, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rename_stage.md
RENAME_STAGE -- requirements
Module: rename_stage

Interface
REQ-001 Parameters: NUM_AREGS, default 16, number of architectural registers; NUM_PREGS, default 64, number of physical registers (P = $clog2(NUM_PREGS), A = $clog2(NUM_AREGS)).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset (reset==0 at a rising edge resets the block).
REQ-004 clear  in  1  pipeline flush; drops the output group.
REQ-005 prev_valid, enabled, next_enabled, next_stalled  in  1 each  pipeline handshake from decode and dispatch.
REQ-006 stalled, valid  out  1 each  backpressure to decode; output group valid.
REQ-007 rs1_k, rs2_k, rd_k  in  A each (k=1,2)  architectural sources and destination of slot k.
REQ-008 writes_k, is_branch_k, is_noop_k  in  1 each (k=1,2)  slot k writes rd_k, is a branch, is a noop.
REQ-009 preg1, preg2  in  P each  freshly allocated physical registers from decode.
REQ-010 num_execute  in  2  count of pregs decode allocated for this group.
REQ-011 prs1_k, prs2_k, prd_k, old_prd_k  out  P each (k=1,2)  renamed sources, new destination, displaced mapping.
REQ-012 out_noop_k  out  1 each  registered copy of is_noop_k.
REQ-013 restore, resolve  in  1 each  branch mispredict (roll back to checkpoint) and branch correct (release checkpoint).
REQ-014 ckpt_valid  out  1  a checkpoint is held.

Function
REQ-015 Internal state: RAT of NUM_AREGS entries × P bits, one checkpoint RAT copy, and ckpt_valid.
REQ-016 Slot k "renames" iff !is_noop_k && writes_k && rd_k != 0; areg 0 always maps to preg 0 and is never written.
REQ-017 Preg assignment: the first renaming slot takes preg1 and the second renaming slot takes preg2; a non-renaming slot outputs prd_k = 0 and old_prd_k = 0.
REQ-018 The number of renaming slots equals num_execute; this is an upstream guarantee, and the block does not check it.
REQ-019 Sources read the RAT combinationally, with intra-group bypass: if slot 1 renames and rs*_2 == rd_1, then prs*_2 = slot 1's new preg.
REQ-020 old_prd_k = RAT[rd_k] before this group; if both slots rename the same rd, old_prd_2 = slot 1's new preg.
REQ-021 RAT write on accept: slot 1 is applied, then slot 2, so slot 2 wins on the same rd.
REQ-022 Accept occurs when enabled && prev_valid && !restore; all outputs register and valid <= 1 one cycle later (latency 1).
REQ-023 When enabled && !prev_valid: valid <= 0 and the RAT is unchanged. When !enabled && next_enabled: valid <= 0. Otherwise outputs hold.
REQ-024 branch_block = prev_valid && (is_branch_1 || is_branch_2) && ckpt_valid.
REQ-025 stalled = (valid && next_stalled) || branch_block; while branch_block is high, the group is not accepted and the RAT is unchanged.
REQ-026 Checkpoint on accepting a branch:
- Branch in slot 1: capture the RAT including slot 1's write but excluding slot 2's write.
- Branch in slot 2 only: capture the RAT including both writes.
- Both slots branches: checkpoint slot 1; slot 2 is treated as a non-branch.
- In all cases ckpt_valid <= 1.
REQ-027 restore with ckpt_valid: RAT <= checkpoint, ckpt_valid <= 0, valid <= 0 next cycle; this overrides any accept in the same cycle.
REQ-028 restore with !ckpt_valid is ignored.
REQ-029 resolve: ckpt_valid <= 0 and the RAT is unchanged.
REQ-030 resolve and restore in the same cycle: restore wins.
REQ-031 resolve in the same cycle as a new branch accept: the new checkpoint is taken and ckpt_valid stays 1.
REQ-032 clear: valid <= 0 next cycle; RAT and checkpoint are unchanged unless restore is also asserted.

Reset
REQ-033 On reset==0 at a clock edge:
- RAT[i] = i and checkpoint[i] = i for all i.
- ckpt_valid = 0 and valid = 0.
- All prs/prd/old_prd outputs = 0 and out_noop_k = 0.
REQ-034 Reset overrides clear, restore, resolve and enabled.
REQ-035 A reset asserted mid-operation discards any held checkpoint.

Verification
REQ-036 After reset, group {slot1: rd=3, rs1=3; slot2: rd=4, rs1=3}, preg1=20, preg2=21 -> prs1_1=3, prd_1=20, old_prd_1=3, prs1_2=20, prd_2=21, old_prd_2=4.
REQ-037 Both slots rd=5, preg1=30, preg2=31 -> old_prd_1=5, old_prd_2=30, RAT[5]=31; slot with rd=0 and writes=1 -> prd=0, RAT[0] stays 0.
REQ-038 Branch in slot 1 renaming r2->40, slot 2 renaming r2->41, then restore -> RAT[2]=40, ckpt_valid=0, valid=0 next cycle.
REQ-039 With ckpt_valid=1, present a branch group -> stalled=1 and RAT unchanged; assert resolve -> group accepted the next enabled cycle and ckpt_valid=1.
REQ-040 valid=1, next_stalled=1 -> stalled=1 and outputs held; reset driven to 0 mid-stream -> valid=0 and RAT identity one cycle later.
REQ-041 restore and resolve in the same cycle with ckpt_valid=1 -> RAT equals checkpoint and ckpt_valid=0.
